// File: rtl/somador_if.sv
// Dual-rail full-adder bus: operand and carry-in rails in, sum/carry rails plus
// completion and illegal-code flags out.
interface somador_if;
    logic A_t, A_f;
    logic B_t, B_f;
    logic Cin_t, Cin_f;
    logic Soma_t, Soma_f;
    logic Cout_t, Cout_f;
    logic ko;
    logic err;

    modport master (
        output A_t, A_f, B_t, B_f, Cin_t, Cin_f,
        input  Soma_t, Soma_f, Cout_t, Cout_f, ko, err
    );

    modport slave (
        input  A_t, A_f, B_t, B_f, Cin_t, Cin_f,
        output Soma_t, Soma_f, Cout_t, Cout_f, ko, err
    );
endinterface

// File: rtl/somador.sv
// Registered dual-rail (NCL-style) full adder with NULL/DATA hysteresis,
// completion output ko and an illegal-code flag.
module somador (
    input  logic       clk,
    input  logic       rst,
    somador_if.slave   bus
);
    typedef enum logic {OUT_NULL = 1'b0, OUT_DATA = 1'b1} state_t;

    state_t state_q, state_d;
    logic   soma_t_q, soma_t_d, soma_f_q, soma_f_d;
    logic   cout_t_q, cout_t_d, cout_f_q, cout_f_d;
    logic   ko_q, ko_d;
    logic   err_q, err_d;

    logic illegal, data_done, null_done;
    logic a, b, c, sum_v, carry_v;

    always_comb begin
        illegal   = (bus.A_t & bus.A_f) | (bus.B_t & bus.B_f) | (bus.Cin_t & bus.Cin_f);
        // Legal DATA on every pair means exactly one rail high per pair.
        data_done = (bus.A_t ^ bus.A_f) & (bus.B_t ^ bus.B_f) & (bus.Cin_t ^ bus.Cin_f);
        null_done = ~(bus.A_t | bus.A_f | bus.B_t | bus.B_f | bus.Cin_t | bus.Cin_f);
        a         = bus.A_t;
        b         = bus.B_t;
        c         = bus.Cin_t;
        sum_v     = a ^ b ^ c;
        carry_v   = (a & b) | (a & c) | (b & c);
    end

    always_comb begin
        state_d  = state_q;
        soma_t_d = soma_t_q;
        soma_f_d = soma_f_q;
        cout_t_d = cout_t_q;
        cout_f_d = cout_f_q;
        ko_d     = ko_q;
        err_d    = illegal;
        unique case (state_q)
            OUT_NULL: begin
                if (data_done) begin
                    state_d  = OUT_DATA;
                    soma_t_d = sum_v;
                    soma_f_d = ~sum_v;
                    cout_t_d = carry_v;
                    cout_f_d = ~carry_v;
                    ko_d     = 1'b0;
                end
            end
            OUT_DATA: begin
                if (null_done) begin
                    state_d  = OUT_NULL;
                    soma_t_d = 1'b0;
                    soma_f_d = 1'b0;
                    cout_t_d = 1'b0;
                    cout_f_d = 1'b0;
                    ko_d     = 1'b1;
                end
            end
            default: state_d = OUT_NULL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= OUT_NULL;
            soma_t_q <= 1'b0;
            soma_f_q <= 1'b0;
            cout_t_q <= 1'b0;
            cout_f_q <= 1'b0;
            ko_q     <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            soma_t_q <= soma_t_d;
            soma_f_q <= soma_f_d;
            cout_t_q <= cout_t_d;
            cout_f_q <= cout_f_d;
            ko_q     <= ko_d;
            err_q    <= err_d;
        end
    end

    assign bus.Soma_t = soma_t_q;
    assign bus.Soma_f = soma_f_q;
    assign bus.Cout_t = cout_t_q;
    assign bus.Cout_f = cout_f_q;
    assign bus.ko     = ko_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_somador.sv
// Directed bench for the dual-rail full adder; observed word is
// {Soma_t, Soma_f, Cout_t, Cout_f, ko, err}.
module tb_somador;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    somador_if bus ();

    somador dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] NUL = 2'b00;
    localparam logic [1:0] ZER = 2'b01;
    localparam logic [1:0] ONE = 2'b10;
    localparam logic [1:0] ILL = 2'b11;

    localparam logic [5:0] W_NULL = 6'b000010;

    task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        {bus.A_t, bus.A_f}     = a;
        {bus.B_t, bus.B_f}     = b;
        {bus.Cin_t, bus.Cin_f} = c;
    endtask

    task automatic edges(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string tag, input logic [5:0] expv);
        logic [5:0] obs;
        obs = {bus.Soma_t, bus.Soma_f, bus.Cout_t, bus.Cout_f, bus.ko, bus.err};
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Hand table (Soma,Cout) indexed by {A,B,Cin}
    logic [1:0] tt [8];
    logic [1:0] rail_a, rail_b, rail_c;
    logic [5:0] w_data;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tt[0] = 2'b00; tt[1] = 2'b10; tt[2] = 2'b10; tt[3] = 2'b01;
        tt[4] = 2'b10; tt[5] = 2'b01; tt[6] = 2'b01; tt[7] = 2'b11;

        rst = 1'b1;
        drive(ONE, ONE, ONE);
        @(negedge clk);
        edges(2);
        check("reset", W_NULL);
        rst = 1'b0;
        drive(NUL, NUL, NUL);
        edges(1);
        check("reset_null_hold", W_NULL);

        for (int i = 0; i < 8; i++) begin
            rail_a = i[2] ? ONE : ZER;
            rail_b = i[1] ? ONE : ZER;
            rail_c = i[0] ? ONE : ZER;
            w_data = {tt[i][1], ~tt[i][1], tt[i][0], ~tt[i][0], 2'b00};
            drive(rail_a, rail_b, rail_c);
            edges(1);
            check($sformatf("tt%0d_lat1", i), w_data);
            edges(1);
            check($sformatf("tt%0d_data", i), w_data);
            drive(NUL, NUL, NUL);
            edges(2);
            check($sformatf("tt%0d_null", i), W_NULL);
        end

        drive(ONE, ONE, NUL);
        for (int i = 0; i < 3; i++) begin
            edges(1);
            check($sformatf("partial_%0d", i), W_NULL);
        end
        drive(ONE, ONE, ZER);
        edges(1);
        check("partial_complete", 6'b011000);

        drive(ONE, ONE, ONE);
        edges(2);
        check("data_to_data_hold", 6'b011000);
        drive(NUL, NUL, NUL);
        edges(1);
        check("null_after_data", W_NULL);
        drive(ONE, ONE, ONE);
        edges(1);
        check("data_111", 6'b101000);
        drive(NUL, ONE, ONE);
        edges(2);
        check("hyst_partial_null", 6'b101000);
        drive(NUL, NUL, NUL);
        edges(1);
        check("hyst_full_null", W_NULL);

        drive(ILL, ZER, ZER);
        edges(1);
        check("illegal_err", 6'b000011);
        drive(ZER, ZER, ZER);
        edges(1);
        check("illegal_clear", 6'b010100);

        drive(NUL, NUL, NUL);
        edges(1);
        check("pre_rst_null", W_NULL);
        drive(ONE, ZER, ONE);
        edges(1);
        check("pre_rst_data", 6'b011000);
        rst = 1'b1;
        edges(1);
        check("mid_rst", W_NULL);
        rst = 1'b0;
        edges(1);
        check("post_rst_data", 6'b011000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/somador.md
SOMADOR -- requirements
Module: somador

Interface
- REQ-001: No parameters; all ports are 1 bit.
- REQ-002: clk  input  1  single clock; all state updates on the rising edge.
- REQ-003: rst  input  1  reset, synchronous and active-high.
- REQ-004: A_t, A_f  input  1 each  dual-rail operand A (true rail, false rail).
- REQ-005: B_t, B_f  input  1 each  dual-rail operand B.
- REQ-006: Cin_t, Cin_f  input  1 each  dual-rail carry-in.
- REQ-007: Soma_t, Soma_f  output  1 each  dual-rail sum.
- REQ-008: Cout_t, Cout_f  output  1 each  dual-rail carry-out.
- REQ-009: ko  output  1  completion/acknowledge.
  - ko=1: outputs are NULL and ready for DATA.
  - ko=0: outputs hold DATA.
- REQ-010: err  output  1  illegal-code flag, registered.

Function
- REQ-011: Dual-rail encoding per signal pair (t,f):
  - (0,0) = NULL.
  - (0,1) = logic 0.
  - (1,0) = logic 1.
  - (1,1) = illegal.
- REQ-012: Input wavefront classification, per sample:
  - DATA-complete: all three inputs are legal DATA.
  - NULL-complete: all three inputs are NULL.
  - Otherwise partial.
- REQ-013: Internal state is one of two states, OUT_NULL and OUT_DATA, held in registers together with the output rails.
- REQ-014: OUT_NULL with a DATA-complete sample: next edge enters OUT_DATA.
  - Sum value = A xor B xor Cin.
  - Carry value = majority(A, B, Cin).
  - Each output is driven on its dual-rail code.
- REQ-015: OUT_DATA with a NULL-complete sample: next edge enters OUT_NULL, and all four output rails go to 0.
- REQ-016: Hysteresis: in any other case, state and outputs hold.
  - Covers partial wavefronts.
  - Covers DATA-to-different-DATA changes without an intervening NULL.
  - Covers NULL while already in OUT_NULL.
- REQ-017: Latency is exactly one clock edge from a complete wavefront at the inputs to the corresponding output change.
- REQ-018: Outputs never present (1,1) and never present mixed NULL/DATA between Soma and Cout; both pairs change on the same edge.
- REQ-019: ko = 1 in OUT_NULL and 0 in OUT_DATA, registered with the outputs.
- REQ-020: Any input pair (1,1) in a sample:
  - err=1 on the next edge.
  - The sample counts as partial, so state holds.
  - err returns to 0 on the first edge whose sample has no illegal pair.
- REQ-021: Required DATA truth table as (A,B,Cin) -> (Soma,Cout):
  - 000->00, 001->10, 010->10, 011->01.
  - 100->10, 101->01, 110->01, 111->11.

Reset
- REQ-022: While rst=1 at a rising edge, the block resets regardless of inputs:
  - State = OUT_NULL.
  - Soma_t = Soma_f = Cout_t = Cout_f = 0.
  - ko = 1, err = 0.
- REQ-023: Reset asserted during OUT_DATA returns outputs to NULL on that edge.
- REQ-024: After rst deasserts, the first DATA-complete sample is processed normally.

Verification
- REQ-025: Full truth table, each of the 8 (A,B,Cin) combinations in turn.
  - Stimulus: DATA, wait 2 edges, check REQ-021 outputs, then all-NULL for 2 edges.
  - Required: each DATA check passes, and after each NULL phase all output rails are 0 with ko=1.
- REQ-026: Partial wavefront.
  - Stimulus: from OUT_NULL, A=1, B=1, Cin=NULL for 3 edges.
  - Required: outputs stay NULL and ko=1.
  - Then Cin=0: next edge gives Soma=0 (0,1), Cout=1 (1,0), ko=0.
- REQ-027: Hysteresis on NULL.
  - Stimulus: in OUT_DATA with A=B=Cin=1, set A=NULL only.
  - Required: outputs hold Soma=(1,0), Cout=(1,0).
  - Then all inputs NULL: next edge gives all rails 0.
- REQ-028: Illegal code.
  - Stimulus: A=(1,1), B=0, Cin=0.
  - Required: err=1 next edge, outputs unchanged.
  - Then A=(0,1): err=0, outputs become Soma=0, Cout=0 in dual-rail form.
- REQ-029: Reset mid-operation.
  - Stimulus: in OUT_DATA (A=1, B=0, Cin=1), assert rst for 1 edge with inputs held at DATA.
  - Required: all rails 0, ko=1.
  - After deassert, the next edge re-enters OUT_DATA with Soma=0, Cout=1.
